dpram_port_arbiter: RTL and testbench
=====================================

# dpram_port_arbiter

Round-robin arbiter that shares one port of the byte-write true-dual-port block RAM between NUM_MST requesters, e.g. CPU, blitter/DMA and debug access on the A port.
- Sequences each access as one registered RAM enable cycle followed by one response cycle.
- Returns read-first data and a single-cycle acknowledge to the granted requester.
- The other RAM port stays free for the chip bus.

## Interface
- NUM_MST, 3: number of requesters, 2..4.
- NUM_COL, 4: byte lanes per word.
- COL_WIDTH, 8: bits per lane.
- ADDR_WIDTH, 8: RAM word address width.
- DATA_WIDTH, NUM_COL*COL_WIDTH: word width.
- clk  in  1  single clock for the arbiter and the RAM port.
- rst_n  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MST  access request per master; held until its m_ack.
- m_we  in  NUM_MST  1 = write, 0 = read.
- m_be  in  NUM_MST*NUM_COL  byte enables; master k owns slice k.
- m_addr  in  NUM_MST*ADDR_WIDTH  word address per master.
- m_wdata  in  NUM_MST*DATA_WIDTH  write data per master.
- m_ack  out  NUM_MST  one-cycle completion strobe, one-hot or zero.
- m_rdata  out  DATA_WIDTH  read data, valid only while any m_ack bit is high.
- grant_idx  out  2  index of the master currently owning the port.
- busy  out  1  high in ISSUE and RESP.
- ram_en  out  1  RAM port enable.
- ram_we  out  NUM_COL  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  registered RAM output, read-first.

## Operation
- States: IDLE, ISSUE, RESP.
- **IDLE**
  - If any m_req: select winner, latch its index, load ram_addr, ram_din and ram_we, go to ISSUE.
  - Otherwise stay in IDLE.
  - ram_we = m_be slice when m_we is high, else 0.
- **ISSUE**
  - ram_en = 1 for exactly this cycle.
  - Go to RESP unconditionally.
- **RESP**
  - m_ack[grant_idx] = 1.
  - m_rdata = ram_dout. Writes also return the pre-write word (read-first).
  - Arbitrate again with the just-acked master masked out, since its req may still be high this cycle.
    - A winner exists: load it and go directly to ISSUE.
    - No winner: go to IDLE.
- **Round-robin selection**
  - Search starts at rr_ptr and wraps modulo NUM_MST; the first requester found wins.
  - rr_ptr = winner+1 (wrapping) at each grant. rr_ptr resets to 0.
- **Boundary conditions**
  - Request inputs are sampled only in IDLE and RESP. A req dropped during ISSUE still completes and still acks.
  - A write followed by a read of the same address from another master returns the new data, because accesses are strictly serialized.
  - Reset mid-access: the access is abandoned, no ack is issued, and the RAM contents are whatever the RAM has already captured.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_idx 0.
  - m_ack 0, busy 0.
  - ram_en 0, ram_we 0, ram_addr 0, ram_din 0.
  - m_rdata follows ram_dout and is don't-care while no m_ack bit is high.
- Latency: m_req high in cycle 0 from IDLE gives ram_en in cycle 1 and m_ack plus valid m_rdata in cycle 2.
- Throughput: back-to-back grants give one access every 2 cycles (ISSUE/RESP alternating).
- Masters may re-raise or hold m_req in the cycle after m_ack. It is treated as a new request.
- All outputs except m_rdata are registered.

## Configuration
- DPARB_FIXED_PRIO_EN
  - Defined: rr_ptr is held at 0 and the lowest-index requesting master always wins. The RESP masking of the just-acked master still applies.
  - Undefined: round-robin as specified above.

## Test plan
- **Single read:** RAM preloaded 0x11223344 at 0x05; m_req[0] with read at 0x05 in cycle 0 -> ram_en=1 in cycle 1, m_ack=3'b001 and m_rdata=0x11223344 in cycle 2.
- **Byte write:** m1 writes be=4'b0101, wdata 0xAABBCCDD to 0x05 -> ram_we=4'b0101 during ISSUE; a following read returns 0x11BB33DD.
- **Simultaneous requests after reset:** m0 and m1 requesting in cycle 0 -> m0 acked in cycle 2, m1 ram_en in cycle 3, m1 acked in cycle 4, busy continuously high for cycles 1–4.
- **Saturation:** all three masters requesting continuously -> ack order 0,1,2,0,1,2, acks in every even cycle starting at cycle 2.
- **Reset mid-access:** rst_n low during ISSUE -> all outputs 0 immediately, no m_ack; a later request from m2 completes normally in 2 cycles.
- **With DPARB_FIXED_PRIO_EN:** m0 re-requesting every cycle after its ack while m1 holds req -> m1 is served only in the RESP slots where m0 is masked, giving an m0/m1 alternation that never starves m1; with m0 and m2 also requesting, m2 is never granted while m0 and m1 keep requesting.

Source files
------------

// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the shared RAM port arbiter.
// Packed per-master slices; master k owns slice k of every vector.
interface dpram_port_arbiter_if #(
  parameter int NUM_MST    = 3,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
);
  logic [NUM_MST-1:0]            m_req;
  logic [NUM_MST-1:0]            m_we;
  logic [NUM_MST*NUM_COL-1:0]    m_be;
  logic [NUM_MST*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MST*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MST-1:0]            m_ack;
  logic [DATA_WIDTH-1:0]         m_rdata;

  modport master (
    output m_req,
    output m_we,
    output m_be,
    output m_addr,
    output m_wdata,
    input  m_ack,
    input  m_rdata
  );

  modport slave (
    input  m_req,
    input  m_we,
    input  m_be,
    input  m_addr,
    input  m_wdata,
    output m_ack,
    output m_rdata
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one byte-write RAM port among requesters.
// Define DPARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module dpram_port_arbiter #(
  parameter int NUM_MST    = 3,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dpram_port_arbiter_if.slave   bus,
  output logic [1:0]            grant_idx,
  output logic                  busy,
  output logic                  ram_en,
  output logic [NUM_COL-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } stateT;

  stateT state;
  stateT stateNxt;

  logic [1:0]            rrPtr;
  logic [1:0]            rrNxt;
  logic [1:0]            ord [NUM_MST];
  logic [NUM_MST-1:0]    ackOne;
  logic [NUM_MST-1:0]    reqMask;
  logic [NUM_MST-1:0]    ackReg;
  logic                  found;
  logic [1:0]            win;
  logic                  load;
  logic                  selWe;
  logic [NUM_COL-1:0]    selBe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;

  always_comb begin
    ackOne = '0;
    for (int k = 0; k < NUM_MST; k++)
      ackOne[k] = (grant_idx == 2'(k));
  end

  // the master acked this cycle may still hold req; keep it out
  always_comb begin
    reqMask = bus.m_req;
    if (state == RESP)
      reqMask = bus.m_req & ~ackOne;
  end

  always_comb begin
    for (int i = 0; i < NUM_MST; i++)
      ord[i] = 2'((int'(rrPtr) + i) % NUM_MST);
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!found && reqMask[ord[i]]) begin
        found = 1'b1;
        win   = ord[i];
      end
    end
  end

  always_comb begin
    selWe   = 1'b0;
    selBe   = '0;
    selAddr = '0;
    selData = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (win == 2'(k)) begin
        selWe   = bus.m_we[k];
        selBe   = bus.m_be[k*NUM_COL +: NUM_COL];
        selAddr = bus.m_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        selData = bus.m_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
`ifdef DPARB_FIXED_PRIO_EN
    rrNxt = 2'd0;
`else
    rrNxt = (win == 2'(NUM_MST - 1)) ? 2'd0 : win + 2'd1;
`endif
  end

  always_comb begin
    stateNxt = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          stateNxt = ISSUE;
          load     = 1'b1;
        end
      end
      ISSUE: begin
        stateNxt = RESP;
      end
      RESP: begin
        if (found) begin
          stateNxt = ISSUE;
          load     = 1'b1;
        end else begin
          stateNxt = IDLE;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      grant_idx <= '0;
      ackReg    <= '0;
      busy      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      state  <= stateNxt;
      busy   <= (stateNxt != IDLE);
      ram_en <= load;
      ram_we <= (load && selWe) ? selBe : '0;
      ackReg <= (state == ISSUE) ? ackOne : '0;
      if (load) begin
        grant_idx <= win;
        rrPtr     <= rrNxt;
        ram_addr  <= selAddr;
        ram_din   <= selData;
      end
    end
  end

  assign bus.m_ack   = ackReg;
  assign bus.m_rdata = ram_dout;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: read-first RAM, timestamp model,
// per-cycle compare plus literal checks of the ack log.
module tb_dpram_port_arbiter;
  localparam int NM = 3;
  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_port_arbiter_if #(
    .NUM_MST(NM), .NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW)
  ) bus ();

  logic [1:0]    grant_idx;
  logic          busy;
  logic          ram_en;
  logic [NC-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  dpram_port_arbiter #(
    .NUM_MST(NM), .NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_idx(grant_idx), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  function automatic logic [DW-1:0] merge(
    logic [DW-1:0] old, logic [DW-1:0] din, logic [NC-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < NC; b++)
      if (((be >> b) & 4'd1) != 4'd0) m = m | (32'hFF << (8*b));
    return (old & ~m) | (din & m);
  endfunction

  // read-first byte-write RAM port
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= ram[ram_addr];
      ram[ram_addr] <= merge(ram[ram_addr], ram_din, ram_we);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCmp = 0;
  int nBad = 0;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // model: transactions timestamped by issue cycle
  logic [DW-1:0] refMem [256];
  bit            cur = 0;
  int            curMst = 0;
  int            curIssue = 0;
  logic [AW-1:0] curAddr = '0;
  bit            curWe = 0;
  logic [NC-1:0] curBe = '0;
  logic [DW-1:0] curData = '0;
  int            rr = 0;
  int            mcyc = 0;
  logic          eBusy = 0;
  logic          eEn = 0;
  logic [NC-1:0] eWe = '0;
  logic [AW-1:0] eAddr = '0;
  logic [DW-1:0] eDin = '0;
  logic [1:0]    eGrant = '0;
  logic [NM-1:0] eAck = '0;
  logic [DW-1:0] eRdata = '0;

  task automatic modelReset();
    cur = 0; rr = 0; eBusy = 0; eEn = 0; eWe = '0;
    eAddr = '0; eDin = '0; eGrant = '0; eAck = '0;
  endtask

  task automatic modelStep();
    int w;
    int k;
    int maskM;
    bit freeNow;
    eEn = 0; eWe = '0; eAck = '0;
    freeNow = !cur || (mcyc == curIssue + 1);
    maskM = (cur && mcyc == curIssue + 1) ? curMst : -1;
    if (cur && mcyc == curIssue) begin
      eAck = NM'(1) << curMst;
      eRdata = refMem[curAddr];
      if (curWe) refMem[curAddr] = merge(refMem[curAddr], curData, curBe);
    end
    if (freeNow) begin
      cur = 0; eBusy = 0; w = -1;
      for (int i = 0; i < NM; i++) begin
        k = (rr + i) % NM;
        if (w < 0 && k != maskM && ((bus.m_req >> k) & 1) != 0) w = k;
      end
      if (w >= 0) begin
        cur = 1; curMst = w; curIssue = mcyc + 1;
        curWe = ((bus.m_we >> w) & 1) != 0;
        curBe = NC'(bus.m_be >> (w*NC));
        curAddr = AW'(bus.m_addr >> (w*AW));
        curData = DW'(bus.m_wdata >> (w*DW));
        eEn = 1; eWe = curWe ? curBe : '0;
        eAddr = curAddr; eDin = curData;
        eGrant = 2'(w); eBusy = 1;
`ifndef DPARB_FIXED_PRIO_EN
        rr = (w + 1) % NM;
`endif
      end
    end else begin
      eBusy = 1;
    end
    mcyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  int ackCyc [$];
  int ackMst [$];
  logic [DW-1:0] ackData [$];
  int enCyc [$];
  bit busyAt [int];
  logic [NM-1:0] ackSeen = '0;

  initial begin
    forever begin
      @(negedge clk);
      cmp("busy", 32'(busy), 32'(eBusy));
      cmp("ram_en", 32'(ram_en), 32'(eEn));
      cmp("ram_we", 32'(ram_we), 32'(eWe));
      cmp("ram_addr", 32'(ram_addr), 32'(eAddr));
      cmp("ram_din", ram_din, eDin);
      cmp("grant_idx", 32'(grant_idx), 32'(eGrant));
      cmp("m_ack", 32'(bus.m_ack), 32'(eAck));
      if (eAck != '0) cmp("m_rdata", bus.m_rdata, eRdata);
      ackSeen = bus.m_ack;
      busyAt[cyc] = busy;
      if (ram_en) enCyc.push_back(cyc);
      for (int k = 0; k < NM; k++) begin
        if (((bus.m_ack >> k) & 1) != 0) begin
          ackCyc.push_back(cyc);
          ackMst.push_back(k);
          ackData.push_back(bus.m_rdata);
        end
      end
    end
  end

  bit [NM-1:0] hold = '0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NM; k++)
      if (((ackSeen >> k) & 1) != 0 && hold[k] == 1'b0)
        bus.m_req = bus.m_req & ~(NM'(1) << k);
  endtask

  task automatic runFor(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic setReq(input int k, input bit we, input logic [NC-1:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_we = (bus.m_we & ~(NM'(1) << k)) | (NM'(we) << k);
    bus.m_be = (bus.m_be & ~((NM*NC)'(4'hF) << (k*NC))) | ((NM*NC)'(be) << (k*NC));
    bus.m_addr = (bus.m_addr & ~((NM*AW)'(8'hFF) << (k*AW))) | ((NM*AW)'(a) << (k*AW));
    bus.m_wdata = (bus.m_wdata & ~((NM*DW)'(32'hFFFF_FFFF) << (k*DW)))
                | ((NM*DW)'(d) << (k*DW));
    bus.m_req = bus.m_req | (NM'(1) << k);
  endtask

  task automatic doReset();
    bus.m_req = '0; hold = '0;
    rst_n = 1'b0;
    runFor(2);
    rst_n = 1'b1;
    runFor(1);
  endtask

  function automatic int qi(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [DW-1:0] qd(input logic [DW-1:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  int t0, t1, n0, e0, nb;
  int order [6];

  initial begin
    bus.m_req = '0; bus.m_we = '0; bus.m_be = '0;
    bus.m_addr = '0; bus.m_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'(i) * 32'h0101_0101;
      refMem[i] = 32'(i) * 32'h0101_0101;
    end
    ram[5] = 32'h1122_3344;
    refMem[5] = 32'h1122_3344;

    runFor(3);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_en", 32'(ram_en), 32'd0);
    cmp("rst_grant", 32'(grant_idx), 32'd0);
    cmp("rst_ack", 32'(bus.m_ack), 32'd0);
    rst_n = 1'b1;
    runFor(2);

    // single read
    t0 = cyc; n0 = ackCyc.size(); e0 = enCyc.size();
    setReq(0, 0, 4'hF, 8'h05, '0);
    runFor(4);
    cmp("rd_en_cyc", 32'(qi(enCyc, e0)), 32'(t0 + 1));
    cmp("rd_ack_cyc", 32'(qi(ackCyc, n0)), 32'(t0 + 2));
    cmp("rd_ack_mst", 32'(qi(ackMst, n0)), 32'd0);
    cmp("rd_data", qd(ackData, n0), 32'h1122_3344);

    // byte write then read from another master
    t0 = cyc; n0 = ackCyc.size();
    setReq(1, 1, 4'b0101, 8'h05, 32'hAABB_CCDD);
    runFor(4);
    cmp("wr_ack_cyc", 32'(qi(ackCyc, n0)), 32'(t0 + 2));
    cmp("wr_pre_data", qd(ackData, n0), 32'h1122_3344);
    t0 = cyc;
    setReq(2, 0, 4'hF, 8'h05, '0);
    runFor(4);
    cmp("rb_ack_mst", 32'(qi(ackMst, n0 + 1)), 32'd2);
    cmp("rb_data", qd(ackData, n0 + 1), 32'h11BB_33DD);

    // simultaneous m0/m1 after reset
    doReset();
    t0 = cyc; n0 = ackCyc.size();
    setReq(0, 0, 4'hF, 8'h01, '0);
    setReq(1, 0, 4'hF, 8'h02, '0);
    runFor(6);
    cmp("sim_ack0_cyc", 32'(qi(ackCyc, n0)), 32'(t0 + 2));
    cmp("sim_ack0_mst", 32'(qi(ackMst, n0)), 32'd0);
    cmp("sim_ack0_data", qd(ackData, n0), 32'h0101_0101);
    cmp("sim_ack1_cyc", 32'(qi(ackCyc, n0 + 1)), 32'(t0 + 4));
    cmp("sim_ack1_mst", 32'(qi(ackMst, n0 + 1)), 32'd1);
    cmp("sim_ack1_data", qd(ackData, n0 + 1), 32'h0202_0202);
    nb = 0;
    for (int c = t0 + 1; c <= t0 + 4; c++)
      if (busyAt.exists(c) && busyAt[c]) nb++;
    cmp("sim_busy_run", 32'(nb), 32'd4);

    // saturation
    doReset();
    t0 = cyc; n0 = ackCyc.size();
    hold = '1;
    setReq(0, 0, 4'hF, 8'h10, '0);
    setReq(1, 0, 4'hF, 8'h11, '0);
    setReq(2, 0, 4'hF, 8'h12, '0);
    runFor(13);
    bus.m_req = '0; hold = '0;
    runFor(4);
`ifdef DPARB_FIXED_PRIO_EN
    order = '{0, 1, 0, 1, 0, 1};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) begin
      cmp("sat_cyc", 32'(qi(ackCyc, n0 + i)), 32'(t0 + 2 + 2*i));
      cmp("sat_mst", 32'(qi(ackMst, n0 + i)), 32'(order[i]));
    end

    // reset during ISSUE of a write
    doReset();
    t0 = cyc;
    setReq(0, 1, 4'hF, 8'h07, 32'hDEAD_BEEF);
    step();
    n0 = ackCyc.size();
    rst_n = 1'b0;
    bus.m_req = '0;
    @(negedge clk);
    cmp("mid_rst_en", 32'(ram_en), 32'd0);
    cmp("mid_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    runFor(2);
    t1 = cyc;
    setReq(2, 0, 4'hF, 8'h07, '0);
    runFor(4);
    cmp("mid_ack_cnt", 32'(ackCyc.size()), 32'(n0 + 1));
    cmp("mid_ack_cyc", 32'(qi(ackCyc, n0)), 32'(t1 + 2));
    cmp("mid_ack_mst", 32'(qi(ackMst, n0)), 32'd2);
    cmp("mid_data", qd(ackData, n0), 32'h0707_0707);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
